lc3_agu_pipe: RTL
=================

# lc3_agu_pipe

Parametrised, pipelined address generation unit for the LC-3 datapath. It selects a base (PC or SR1), sign-extends one of three IR offset fields, and adds them modulo 2^DATA_W. Results are registered into a 2-entry output queue with valid/ready handshakes on both sides. The block replaces the purely combinational ADDR1MUX/ADDR2MUX adder in front of the MAR/PC load path, so memory-stage backpressure no longer stalls decode combinationally.

## Interface
- DATA_W, 16, address/base width
- OFF0_W, 6, width of short offset field (IR[5:0])
- OFF1_W, 9, width of medium offset field (IR[8:0])
- OFF2_W, 11, width of long offset field (IR[10:0]); all OFFn_W < DATA_W
- USER_LO, 16'h3000, lowest user-accessible address (inclusive)
- USER_HI, 16'hFE00, first address above user space (exclusive)

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_flush  in  1  synchronous queue clear
- i_in_valid  in  1  request present
- o_in_ready  out  1  queue can accept (count < 2)
- i_pc  in  DATA_W  PC base
- i_sr1  in  DATA_W  register base
- i_addr1_sel  in  1  0: PC, 1: SR1
- i_addr2_sel  in  2  00: zero, 01: OFF0, 10: OFF1, 11: OFF2
- i_off0 / i_off1 / i_off2  in  OFF0_W / OFF1_W / OFF2_W  raw IR fields
- i_user  in  1  request issued in user privilege
- o_out_valid  out  1  head entry valid
- i_out_ready  in  1  consumer takes head
- o_addr  out  DATA_W  computed address of head entry
- o_acv  out  1  access-control violation flag of head entry

## Operation
- Offset fields are sign-extended to DATA_W (MSB replicated).
- Sum = base + offset, truncated to DATA_W; carry-out discarded. Example: 16'hFFFF + 1 = 16'h0000.
- Accept: i_in_valid && o_in_ready at a rising edge computes the sum and writes it, plus the ACV flag, to the tail of the queue.
- Pop: o_out_valid && i_out_ready at a rising edge removes the head.
- Queue: 2 entries, strict FIFO order; occupancy count takes values 0..2.
- Combinational outputs: o_in_ready = (count != 2); o_out_valid = (count != 0).
- Simultaneous push and pop: count is unchanged and ordering is preserved. When count == 1, the pushed entry becomes the head on the next cycle.
- Push while full cannot occur, because o_in_ready is low.
- o_addr/o_acv hold their value while o_out_valid && !i_out_ready; a stalled head is never altered.
- i_flush: count becomes 0 on the next edge. Any same-cycle push or pop is discarded, and flush has priority.
- Entry storage is not cleared by flush; only valid state changes.

## Timing
- Latency: a request accepted at edge N appears on o_addr with o_out_valid at edge N (visible in cycle N+1), provided the queue was empty.
- Throughput: 1 request per cycle when i_out_ready is held high.
- Reset (i_rst_n low, asynchronous): count = 0, entries = 0, so o_out_valid = 0, o_addr = 0, o_acv = 0, o_in_ready = 1.
- Reset asserted mid-transfer drops all queued entries immediately. There is no partial state after release.
- With count == 2 and a pop at edge N, o_in_ready rises in cycle N+1. There is no same-cycle fall-through.

## Configuration
- Macro: LC3_AGU_ACV_EN.
- With the macro defined: o_acv = i_user && (sum < USER_LO || sum >= USER_HI), captured with the entry. Supervisor requests (i_user = 0) always give 0.
- Without the macro: o_acv is tied to 0, and neither comparators nor per-entry flag storage are built. The USER_LO/USER_HI parameters are ignored.

## Test plan
- PC-relative with negative offset and wrap: i_pc = 16'h3000, addr1_sel = 0, addr2_sel = 10, i_off1 = 9'h1FF (−1) -> o_addr = 16'h2FFF one cycle later. Repeat with i_pc = 16'hFFFF, i_off0 = 6'h01 -> o_addr = 16'h0000.
- Base+offset with long field: i_sr1 = 16'h4000, sel = 1/11, i_off2 = 11'h400 -> o_addr = 16'h3C00. sel 00 -> o_addr = 16'h4000.
- Backpressure: hold i_out_ready = 0 and send 3 requests (A, B, C) -> A and B accepted, o_in_ready = 0 while C waits. Release i_out_ready -> outputs A, B, C in order, with no o_addr change while stalled.
- Flush with simultaneous push: 2 entries queued, assert i_flush together with i_in_valid -> next cycle o_out_valid = 0, count = 0, and the pushed request is absent.
- ACV (macro on): i_user = 1, sum = 16'h2FFF -> o_acv = 1; sum = 16'hFE00 -> o_acv = 1; sum = 16'h3000 -> o_acv = 0; i_user = 0, sum = 16'hFE00 -> o_acv = 0. With the macro off, all cases give 0.
- Asynchronous reset mid-stream: assert i_rst_n = 0 between edges with 2 entries queued -> o_out_valid = 0, o_addr = 0, o_in_ready = 1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/lc3_agu_pipe.sv
// LC-3 address generation unit: base (PC/SR1) + sign-extended IR offset into a 2-entry output queue.
// Latency: 1 cycle (accept at edge N, head visible in cycle N+1); 1 request/cycle with consumer ready.
// Backpressure: o_in_ready drops when both entries are held; LC3_AGU_ACV_EN adds a user-space ACV flag.
module lc3_agu_pipe #(
    parameter int                DATA_W  = 16,
    parameter int                OFF0_W  = 6,
    parameter int                OFF1_W  = 9,
    parameter int                OFF2_W  = 11,
    parameter logic [DATA_W-1:0] USER_LO = 'h3000,
    parameter logic [DATA_W-1:0] USER_HI = 'hFE00
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_pc,
    input  logic [DATA_W-1:0] i_sr1,
    input  logic              i_addr1_sel,
    input  logic [1:0]        i_addr2_sel,
    input  logic [OFF0_W-1:0] i_off0,
    input  logic [OFF1_W-1:0] i_off1,
    input  logic [OFF2_W-1:0] i_off2,
    input  logic              i_user,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_addr,
    output logic              o_acv
);

    logic [DATA_W-1:0] base;
    logic [DATA_W-1:0] offset;
    logic [DATA_W-1:0] sum;

    always_comb begin
        base   = i_addr1_sel ? i_sr1 : i_pc;
        offset = '0;
        case (i_addr2_sel)
            2'b01:   offset = {{(DATA_W-OFF0_W){i_off0[OFF0_W-1]}}, i_off0};
            2'b10:   offset = {{(DATA_W-OFF1_W){i_off1[OFF1_W-1]}}, i_off1};
            2'b11:   offset = {{(DATA_W-OFF2_W){i_off2[OFF2_W-1]}}, i_off2};
            default: offset = '0;
        endcase
        sum = base + offset;
    end

    logic [DATA_W-1:0] addr_q [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              push, pop, wr_en;

    assign o_in_ready  = (count_q != 2'd2);
    assign o_out_valid = (count_q != 2'd0);
    assign push        = i_in_valid && o_in_ready;
    assign pop         = o_out_valid && i_out_ready;
    assign wr_en       = push && !i_flush;
    assign o_addr      = addr_q[rd_ptr_q];

    // Flush wins over any same-cycle push/pop; stored data is left in place.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            for (int i = 0; i < 2; i++) addr_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (wr_en) addr_q[wr_ptr_q] <= sum;
        end
    end

`ifdef LC3_AGU_ACV_EN
    logic acv_q [2];
    logic acv_new;

    assign acv_new = i_user && ((sum < USER_LO) || (sum >= USER_HI));
    assign o_acv   = acv_q[rd_ptr_q];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 2; i++) acv_q[i] <= 1'b0;
        end else if (wr_en) begin
            acv_q[wr_ptr_q] <= acv_new;
        end
    end
`else
    // Privilege and user-space bounds only matter when the ACV check is built.
    logic unused_cfg;
    assign unused_cfg = ^{USER_LO, USER_HI, i_user};
    assign o_acv      = 1'b0;
`endif

endmodule
